// File: rtl/signed_divider.sv
// Sequential signed divider: restoring division on operand magnitudes with a
// final sign correction; start/done handshake shared with the Booth multiplier.
module signed_divider #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    ovf,
  output logic                    done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] SUB   = 3'd4;
  localparam logic [2:0] FIX   = 3'd5;
  localparam logic [2:0] DZ    = 3'd6;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Control and visible result registers (reset)
  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0] quot_q, quot_d;
  logic signed [WIDTH-1:0] rem_q, rem_d;
  logic                    dbz_q, dbz_d;
  logic                    ovf_q, ovf_d;

  // Datapath working registers (reloaded in INIT, not reset)
  logic [WIDTH-1:0]        q_q, q_d;
  logic [WIDTH:0]          r_q, r_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic                    qneg_q, qneg_d;
  logic                    rneg_q, rneg_d;
  logic signed [WIDTH-1:0] dvd_q, dvd_d;
  logic signed [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH+1:0]        trial;

  // Magnitude of a two's complement value; the most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] ux;
    ux = x;
    return x[WIDTH-1] ? (~ux + WIDTH'(1)) : ux;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] x);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    trial   = {1'b0, r_q} - {2'b00, b_q};

    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        q_d    = abs_val(dividend);
        b_d    = abs_val(divisor);
        qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        rneg_d = dividend[WIDTH-1];
        r_d    = '0;
        cnt_d  = '0;
        dvd_d  = dividend;
        dvs_d  = divisor;
        if (!start) state_d = CHECK;
      end
      CHECK: begin
        state_d = (b_q == '0) ? DZ : SHIFT;
      end
      SHIFT: begin
        {r_d, q_d} = {r_q[WIDTH-1:0], q_q, 1'b0};
        cnt_d      = cnt_q + CW'(1);
        state_d    = SUB;
      end
      SUB: begin
        // A set top bit of the trial difference means R < B: restore.
        r_d     = trial[WIDTH+1] ? r_q : trial[WIDTH:0];
        q_d     = {q_q[WIDTH-1:1], ~trial[WIDTH+1]};
        state_d = (cnt_q == CW'(WIDTH)) ? FIX : SHIFT;
      end
      FIX: begin
        quot_d  = cond_neg(qneg_q, q_q);
        rem_d   = cond_neg(rneg_q, r_q[WIDTH-1:0]);
        ovf_d   = (dvd_q == MOST_NEG) && (dvs_q == '1);
        dbz_d   = 1'b0;
        state_d = IDLE;
      end
      DZ: begin
        quot_d  = '1;
        rem_d   = dvd_q;
        dbz_d   = 1'b1;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    q_q    <= q_d;
    r_q    <= r_d;
    b_q    <= b_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign ovf         = ovf_q;
  assign done        = (state_q == IDLE);

endmodule
